csr_trap_unit: RTL and testbench

Parametrised machine-mode CSR file and trap controller for the RV32I softcore; successor to the fixed-width CSR/exception unit. Holds machine status, trap and counter CSRs, executes CSRRW/S/C(I) from the execute stage, arbitrates exceptions, interrupts and MRET, and issues a one-cycle PC redirect to fetch. Counter width, performance-counter count and mtvec vectored mode are generic.

---
 rtl/csr_trap_unit_if.sv | 44 ++++
 rtl/csr_trap_unit.sv | 190 +++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_trap_unit_if : execute-stage, counter-event and fetch-redirect bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface csr_trap_unit_if #(
    parameter int NUM_HPM = 4
);
    logic               retire;
    logic [NUM_HPM-1:0] hpm_event;
    logic               csr_valid;
    logic [1:0]         csr_op;
    logic               csr_imm;
    logic [11:0]        csr_addr;
    logic [31:0]        rs1_data;
    logic [4:0]         uimm;
    logic               rd_nonzero;
    logic               exc_valid;
    logic [3:0]         exc_cause;
    logic [31:0]        exc_tval;
    logic [31:0]        pc_in;
    logic               mret;
    logic               irq_ext;
    logic               irq_timer;
    logic [31:0]        csr_rdata;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               trap_taken;

    modport slave (
        input  retire, hpm_event, csr_valid, csr_op, csr_imm, csr_addr, rs1_data,
               uimm, rd_nonzero, exc_valid, exc_cause, exc_tval, pc_in, mret,
               irq_ext, irq_timer,
        output csr_rdata, redirect_valid, redirect_pc, trap_taken
    );

    modport master (
        output retire, hpm_event, csr_valid, csr_op, csr_imm, csr_addr, rs1_data,
               uimm, rd_nonzero, exc_valid, exc_cause, exc_tval, pc_in, mret,
               irq_ext, irq_timer,
        input  csr_rdata, redirect_valid, redirect_pc, trap_taken
    );
endinterface
`default_nettype wire

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_trap_unit : machine-mode CSR file, counters and trap/MRET controller
// Rev 1.0
// ---------------------------------------------------------------------------
module csr_trap_unit #(
    parameter int          CNT_WIDTH   = 64,
    parameter int          NUM_HPM     = 4,
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input wire             clk,
    input wire             resetb,
    csr_trap_unit_if.slave bus
);
    localparam int NCNT = NUM_HPM + 2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 mstatus_mie_q, mstatus_mpie_q;
    logic [1:0]           mie_q;
    logic [31:0]          mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [31:0]          csr_rdata_q, redirect_pc_q;
    logic [CNT_WIDTH-1:0] cnt_q [NCNT];

    logic [NCNT-1:0] cnt_inc, cnt_hit, cnt_wr_lo, cnt_wr_hi;
    logic            cnt_addr, known, illegal, wr_req, csr_act, irq_pend;
    logic            run, take_exc, take_ill, take_irq, take_mret, csr_do, csr_we, trap, vec;
    logic [31:0]     rdata, operand, wdata, trap_pc;
    logic [3:0]      trap_cause;

    // Counter slot 0 = mcycle, 1 = minstret, 2+k = mhpmcounter(3+k).
    assign cnt_inc = {bus.hpm_event, bus.retire, 1'b1};

    always_comb begin
        cnt_addr = (bus.csr_addr[6:5] == 2'b00) &&
                   (((bus.csr_addr[11:8] == 4'hB) && (bus.csr_addr[4:0] != 5'd1)) ||
                    ((bus.csr_addr[11:8] == 4'hC) &&
                     ((bus.csr_addr[4:0] == 5'd0) || (bus.csr_addr[4:0] == 5'd2))));
        known = cnt_addr ||
                ((bus.csr_addr[11:5] == 7'b0011_001) && (bus.csr_addr[4:0] >= 5'd3));
        rdata = 32'h0;
        case (bus.csr_addr)
            12'h300: begin
                known = 1'b1;
                rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            end
            12'h301: begin known = 1'b1; rdata = 32'h4000_0100; end
            12'h304: begin known = 1'b1; rdata = {20'b0, mie_q[1], 3'b0, mie_q[0], 7'b0}; end
            12'h305: begin known = 1'b1; rdata = mtvec_q; end
            12'h340: begin known = 1'b1; rdata = mscratch_q; end
            12'h341: begin known = 1'b1; rdata = mepc_q; end
            12'h342: begin known = 1'b1; rdata = mcause_q; end
            12'h343: begin known = 1'b1; rdata = mtval_q; end
            12'h344: begin
                known = 1'b1;
                rdata = {20'b0, bus.irq_ext, 3'b0, bus.irq_timer, 7'b0};
            end
            12'hF11, 12'hF12, 12'hF13, 12'hF14: known = 1'b1;
            default: ;
        endcase
        for (int i = 0; i < NCNT; i++) begin
            cnt_hit[i] = cnt_addr && (bus.csr_addr[4:0] == 5'((i == 0) ? 0 : i + 1));
            if (cnt_hit[i]) begin
                rdata = bus.csr_addr[7] ? 32'(cnt_q[i][CNT_WIDTH-1:32]) : cnt_q[i][31:0];
            end
        end

        operand = bus.csr_imm ? {27'b0, bus.uimm} : bus.rs1_data;
        case (bus.csr_op)
            2'b01:   wdata = operand;
            2'b10:   wdata = rdata | operand;
            2'b11:   wdata = rdata & ~operand;
            default: wdata = rdata;
        endcase
        // Set/clear with a zero source field is a pure read and never writes.
        wr_req  = (bus.csr_op == 2'b01) || (bus.uimm != 5'd0);
        csr_act = bus.csr_valid && (bus.csr_op != 2'b00);
        illegal = csr_act && (!known || (wr_req && (bus.csr_addr[11:10] == 2'b11)));
    end

    always_comb begin
        run       = (state_q == ST_RUN);
        irq_pend  = mstatus_mie_q && ((mie_q[1] && bus.irq_ext) || (mie_q[0] && bus.irq_timer));
        take_exc  = run && bus.exc_valid;
        take_ill  = run && !bus.exc_valid && illegal;
        take_irq  = run && !bus.exc_valid && !illegal && irq_pend;
        take_mret = run && !bus.exc_valid && !illegal && !irq_pend && bus.mret;
        csr_do    = run && csr_act && !bus.exc_valid && !illegal && !irq_pend && !bus.mret;
        csr_we    = csr_do && wr_req;
        trap      = take_exc || take_ill || take_irq;
        if (take_exc)                   trap_cause = bus.exc_cause;
        else if (take_ill)              trap_cause = 4'd2;
        else if (mie_q[1] && bus.irq_ext) trap_cause = 4'd11;
        else                            trap_cause = 4'd7;
        vec     = take_irq && VECTORED_EN && (mtvec_q[1:0] == 2'b01);
        trap_pc = {mtvec_q[31:2], 2'b00} + (vec ? {26'b0, trap_cause, 2'b00} : 32'h0);

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (trap)           state_d = ST_TRAP;
                else if (take_mret) state_d = ST_RET;
            end
            ST_TRAP, ST_RET: state_d = ST_RUN;
            default:         state_d = ST_RUN;
        endcase

        bus.redirect_valid = (state_q != ST_RUN);
        bus.trap_taken     = (state_q == ST_TRAP);
        bus.redirect_pc    = redirect_pc_q;
        bus.csr_rdata      = csr_rdata_q;
    end

    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            cnt_wr_lo[i] = csr_we && cnt_hit[i] && !bus.csr_addr[7];
            cnt_wr_hi[i] = csr_we && cnt_hit[i] && bus.csr_addr[7];
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (cnt_wr_lo[i])      cnt_q[i][31:0]           <= wdata;
                else if (cnt_wr_hi[i]) cnt_q[i][CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
                else                   cnt_q[i]                 <= cnt_q[i] + CNT_WIDTH'(cnt_inc[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 2'b00;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            csr_rdata_q    <= 32'h0;
            redirect_pc_q  <= 32'h0;
        end else if (trap) begin
            mepc_q         <= {bus.pc_in[31:2], 2'b00};
            mcause_q       <= {take_irq, 27'b0, trap_cause};
            mtval_q        <= take_exc ? bus.exc_tval : 32'h0;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            redirect_pc_q  <= trap_pc;
        end else if (take_mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
            redirect_pc_q  <= mepc_q;
        end else if (csr_do) begin
            if (bus.rd_nonzero || (bus.csr_op == 2'b01)) csr_rdata_q <= rdata;
            if (csr_we) begin
                case (bus.csr_addr)
                    12'h300: begin
                        mstatus_mie_q  <= wdata[3];
                        mstatus_mpie_q <= wdata[7];
                    end
                    12'h304: mie_q      <= {wdata[11], wdata[7]};
                    12'h305: mtvec_q    <= {wdata[31:2], 1'b0, VECTORED_EN & wdata[0]};
                    12'h340: mscratch_q <= wdata;
                    12'h341: mepc_q     <= {wdata[31:2], 2'b00};
                    12'h342: mcause_q   <= wdata;
                    12'h343: mtval_q    <= wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// tb_csr_trap_unit: directed scoreboard bench for csr_trap_unit (CNT_WIDTH=40, NUM_HPM=4).
module tb_csr_trap_unit;
    localparam int NUM_HPM = 4;
    localparam int K_RDATA = 0;
    localparam int K_RV    = 1;
    localparam int K_RPC   = 2;
    localparam int K_TT    = 3;

    logic clk = 1'b0;
    logic resetb;
    int   checks = 0;
    int   errors = 0;

    string       sb_tag[$];
    int          sb_kind[$];
    logic [31:0] sb_exp[$];

    csr_trap_unit_if #(.NUM_HPM(NUM_HPM)) bus ();

    csr_trap_unit #(
        .CNT_WIDTH  (40),
        .NUM_HPM    (NUM_HPM),
        .VECTORED_EN(1'b1),
        .MTVEC_RESET(32'h0000_0100)
    ) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input int kind, input logic [31:0] val);
        sb_tag.push_back(tag);
        sb_kind.push_back(kind);
        sb_exp.push_back(val);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RDATA: return bus.csr_rdata;
            K_RV:    return {31'b0, bus.redirect_valid};
            K_RPC:   return bus.redirect_pc;
            default: return {31'b0, bus.trap_taken};
        endcase
    endfunction

    task automatic drain();
        while (sb_exp.size() != 0) begin
            string       t;
            int          k;
            logic [31:0] e;
            logic [31:0] o;
            t = sb_tag.pop_front();
            k = sb_kind.pop_front();
            e = sb_exp.pop_front();
            o = observe(k);
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle();
        bus.csr_valid  = 1'b0;
        bus.csr_op     = 2'b00;
        bus.csr_imm    = 1'b0;
        bus.csr_addr   = 12'h000;
        bus.rs1_data   = 32'h0;
        bus.uimm       = 5'd0;
        bus.rd_nonzero = 1'b0;
        bus.exc_valid  = 1'b0;
        bus.mret       = 1'b0;
        bus.retire     = 1'b0;
        bus.hpm_event  = '0;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data,
                       input logic imm, input logic [4:0] ui, input logic rdnz);
        bus.csr_valid  = 1'b1;
        bus.csr_op     = op;
        bus.csr_addr   = addr;
        bus.rs1_data   = data;
        bus.csr_imm    = imm;
        bus.uimm       = ui;
        bus.rd_nonzero = rdnz;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr(2'b10, addr, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b1);
        expect_out(tag, K_RDATA, exp);
        step();
        idle();
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr(2'b01, addr, data, 1'b0, 5'd1, 1'b0);
        step();
        idle();
    endtask

    task automatic expect_redirect(input string tag, input logic rv, input logic tt,
                                   input logic [31:0] pc);
        expect_out({tag, "_rv"}, K_RV, {31'b0, rv});
        expect_out({tag, "_tt"}, K_TT, {31'b0, tt});
        expect_out({tag, "_pc"}, K_RPC, pc);
    endtask

    initial begin
        resetb        = 1'b0;
        idle();
        bus.irq_ext   = 1'b0;
        bus.irq_timer = 1'b0;
        bus.pc_in     = 32'h0;
        bus.exc_cause = 4'd0;
        bus.exc_tval  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        expect_out("rst_rdata", K_RDATA, 32'h0);
        expect_redirect("rst", 1'b0, 1'b0, 32'h0);
        drain();
        resetb = 1'b1;

        // Ten idle edges after reset release, then the read edge sees exactly 10.
        repeat (10) step();
        rd("mcycle_after_reset", 12'hB00, 32'd10);
        rd("mhartid", 12'hF14, 32'h0);
        rd("misa", 12'h301, 32'h4000_0100);
        rd("mtvec_reset", 12'h305, 32'h0000_0100);

        // Write to a read-only user alias traps with cause 2.
        bus.pc_in    = 32'h84;
        bus.exc_tval = 32'h5555_5555;
        csr(2'b01, 12'hC00, 32'h1234, 1'b0, 5'd3, 1'b1);
        expect_redirect("ill_c00", 1'b1, 1'b1, 32'h100);
        step();
        idle();
        expect_redirect("ill_c00_end", 1'b0, 1'b0, 32'h100);
        step();
        rd("ill_mcause", 12'h342, 32'h2);
        rd("ill_mtval", 12'h343, 32'h0);
        rd("ill_mepc", 12'h341, 32'h84);

        // Vectored external interrupt.
        csr(2'b01, 12'h305, 32'h201, 1'b0, 5'd2, 1'b0);
        expect_out("mtvec_old", K_RDATA, 32'h100);
        step();
        idle();
        wr(12'h304, 32'h800);
        wr(12'h300, 32'h8);
        rd("mstatus_mie1", 12'h300, 32'h1808);
        bus.irq_ext = 1'b1;
        bus.pc_in   = 32'h42;
        expect_redirect("irq_ext", 1'b1, 1'b1, 32'h22C);
        step();
        bus.irq_ext = 1'b0;
        expect_out("irq_ext_end_rv", K_RV, 32'h0);
        step();
        rd("irq_mepc", 12'h341, 32'h40);
        rd("irq_mcause", 12'h342, 32'h8000_000B);
        rd("irq_mstatus", 12'h300, 32'h1880);

        // Exception beats a same-cycle enabled timer interrupt; then MRET.
        wr(12'h304, 32'h880);
        csr(2'b10, 12'h300, 32'h0, 1'b1, 5'd8, 1'b0);
        step();
        idle();
        bus.irq_timer = 1'b1;
        bus.exc_valid = 1'b1;
        bus.exc_cause = 4'd3;
        bus.exc_tval  = 32'hDEAD_BEEF;
        bus.pc_in     = 32'h3C8;
        expect_redirect("exc3", 1'b1, 1'b1, 32'h200);
        step();
        idle();
        bus.irq_timer = 1'b0;
        expect_out("exc3_end_rv", K_RV, 32'h0);
        step();
        rd("exc_mcause", 12'h342, 32'h3);
        rd("exc_mtval", 12'h343, 32'hDEAD_BEEF);
        rd("exc_mstatus", 12'h300, 32'h1880);
        bus.mret = 1'b1;
        expect_redirect("mret", 1'b1, 1'b0, 32'h3C8);
        step();
        idle();
        expect_out("mret_end_rv", K_RV, 32'h0);
        step();
        rd("mret_mstatus", 12'h300, 32'h1888);
        wr(12'h300, 32'h0);

        // Set with x0 source does not write; clear with rs1 != x0 does.
        wr(12'h340, 32'h1234_5678);
        csr(2'b10, 12'h340, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b1);
        expect_out("csrrs_x0_old", K_RDATA, 32'h1234_5678);
        step();
        idle();
        rd("mscratch_kept", 12'h340, 32'h1234_5678);
        csr(2'b11, 12'h340, 32'hF, 1'b0, 5'd5, 1'b1);
        expect_out("csrrc_old", K_RDATA, 32'h1234_5678);
        step();
        idle();
        rd("mscratch_cleared", 12'h340, 32'h1234_5670);

        // 40-bit counter: high half truncates to 8 bits, then wraps to zero.
        csr(2'b01, 12'hB80, 32'h1FF, 1'b0, 5'd4, 1'b1);
        expect_out("mcycleh_old", K_RDATA, 32'h0);
        step();
        idle();
        rd("mcycleh_trunc", 12'hB80, 32'hFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        step();
        rd("mcycle_wrap", 12'hB00, 32'h0);
        rd("mcycleh_wrap", 12'hB80, 32'h0);

        // minstret and mhpmcounter3 increments.
        repeat (3) begin
            bus.retire = 1'b1;
            step();
        end
        bus.retire = 1'b0;
        repeat (5) begin
            bus.hpm_event = 4'b0001;
            step();
            bus.hpm_event = 4'b0000;
            step();
        end
        rd("minstret", 12'hB02, 32'd3);
        rd("instret_alias", 12'hC02, 32'd3);
        rd("mhpm4", 12'hB04, 32'd0);
        rd("mhpm3", 12'hB03, 32'd5);
        csr(2'b10, 12'hB07, 32'h0, 1'b0, 5'd0, 1'b1);
        expect_out("mhpm7_rdata", K_RDATA, 32'h0);
        expect_out("mhpm7_notrap", K_RV, 32'h0);
        step();
        idle();
        csr(2'b01, 12'hB07, 32'hABCD, 1'b0, 5'd6, 1'b0);
        expect_out("mhpm7_wr_notrap", K_RV, 32'h0);
        step();
        idle();
        rd("mhpm7_after_wr", 12'hB07, 32'h0);
        rd("mhpmevent3", 12'h323, 32'h0);

        // Unimplemented address traps, direct base even with MODE=01.
        bus.pc_in = 32'h500;
        csr(2'b10, 12'h7C0, 32'h0, 1'b0, 5'd0, 1'b1);
        expect_redirect("unimpl", 1'b1, 1'b1, 32'h200);
        step();
        idle();
        step();
        rd("unimpl_mcause", 12'h342, 32'h2);

        // Async reset during TRAP drops the redirect immediately.
        bus.exc_valid = 1'b1;
        bus.exc_cause = 4'd5;
        expect_out("pre_reset_rv", K_RV, 32'h1);
        step();
        idle();
        #1 resetb = 1'b0;
        #1;
        expect_redirect("mid_trap_reset", 1'b0, 1'b0, 32'h0);
        drain();
        @(posedge clk);
        #1 resetb = 1'b1;
        rd("mtvec_after_reset", 12'h305, 32'h100);
        rd("mscratch_after_reset", 12'h340, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
